mbc_req_seq: RTL and testbench
==============================

Name: mbc_req_seq

Overview:
Parametrised memory-bus request sequencer for the MBOX/MBC path, generalising the fixed quadword core-memory controller. Accepts one cache-side read or write request with a word mask, drives start/address/word-request lines to memory, and waits for acknowledge. It then sequences per-word data-valid traffic in rotated word order and flags non-existent memory on timeout. It sits between the MBX request logic and the external memory bus.

Parameters:
NWORDS, 4, words per memory block; power of two, range 2..16
ADR_W, 14, physical block address width on the memory bus
TIMEOUT, 64, cycles without ackn/data-valid before NXM; range 2..(2^TO_W - 1)
TO_W, 8, timeout counter width

Ports:
clk_mbc_h  in  1  MBC clock
mr_reset_h  in  1  synchronous active-high reset
rq_valid_h  in  1  request offered by MBX
rq_ready_h  out  1  sequencer idle, request accepted when rq_valid_h & rq_ready_h
rq_wr_h  in  1  1 = write, 0 = read
rq_words_h  in  NWORDS  word mask; all-zero means all words
rq_adr_h  in  ADR_W  block address; low log2(NWORDS) bits give first word
rq_par_h  in  1  supplied odd parity of rq_adr_h
mem_start_h  out  1  one-cycle start strobe
mem_adr_h  out  ADR_W  latched address
mem_adr_par_h  out  1  odd parity of mem_adr_h
mem_rq_h  out  NWORDS  latched word-request lines
mem_rd_rq_h  out  1  read cycle in progress
mem_wr_rq_h  out  1  write cycle in progress
mem_ackn_h  in  1  memory acknowledge pulse
mem_data_valid_h  in  1  read data-valid pulse from memory
data_valid_out_h  out  1  write data strobe to memory
word_sel_h  out  log2(NWORDS)  word currently transferring
core_data_valid_h  out  1  read word delivered to cache
core_busy_h  out  1  transaction in progress (not IDLE)
nxm_h  out  1  one-cycle NXM indication
adr_par_err_h  out  1  one-cycle address parity error

Behaviour:
- States: IDLE, START, WAIT_ACK, RD_DATA, WR_DATA.
- Reset (any state, any cycle): state IDLE; every output 0 except rq_ready_h (0 during the reset cycle, 1 the cycle after); latched address/mask cleared; timeout counter 0. Reset mid-transaction abandons it without emitting nxm_h.
- IDLE: rq_ready_h=1. On accept, latch adr, wr, and effective mask (zero mask -> all ones). Compute odd parity of rq_adr_h. If it differs from rq_par_h: adr_par_err_h=1 next cycle, stay IDLE, nothing issued. Otherwise -> START.
- START, one cycle: mem_start_h=1. mem_adr_h, mem_adr_par_h, mem_rq_h, and mem_rd_rq_h or mem_wr_rq_h are valid from START until return to IDLE. mem_start_h appears exactly one cycle after accept. Next state WAIT_ACK; counter cleared.
- WAIT_ACK: mem_ackn_h -> RD_DATA (read) or WR_DATA (write). word_sel_h = first word: the adr low-bit index if that bit is set in the mask, else the next set bit ascending modulo NWORDS. mem_data_valid_h is ignored in this state.
- RD_DATA: each mem_data_valid_h pulse -> core_data_valid_h=1 the next cycle, with word_sel_h = word being delivered; then advance to the next set mask bit (wrap modulo NWORDS). After the last masked word -> IDLE. mem_ackn_h is ignored.
- WR_DATA: data_valid_out_h=1 on consecutive cycles, one per masked word in rotated order, word_sel_h tracking. -> IDLE after the last. No timeout in this state.
- Timeout: counter increments each cycle in WAIT_ACK/RD_DATA and clears on ackn or data-valid. At count == TIMEOUT: nxm_h=1 for one cycle, -> IDLE, outstanding words dropped. If ackn/data-valid arrives in that same cycle, the event wins and there is no NXM.
- Back-to-back: rq_ready_h rises the cycle after the final transfer; a new request may be accepted in that cycle.
- core_busy_h = (state != IDLE).

Decomposition:
- Package mbc_pkg: state enum; odd-parity function; function next_word(mask, idx), returning the next set bit after idx modulo NWORDS.
- Sub-module mbc_word_rotor: combinational first/next set-bit finder over NWORDS with wrap. Used for both first-word and advance selection.

Test Plan:
1. Read, NWORDS=4, adr=0x0006 (first word 2), mask=1111, good parity; ackn at +3, data-valid every 2 cycles -> mem_start_h 1 cycle after accept; core_data_valid_h ×4 with word_sel 2,3,0,1; then IDLE, rq_ready_h=1.
2. Write, mask=0101, adr low bits=1, after ackn -> data_valid_out_h on 2 consecutive cycles with word_sel 2,0; mem_wr_rq_h=1 throughout, mem_rd_rq_h=0.
3. Read, no ackn -> nxm_h pulses exactly TIMEOUT=64 cycles after WAIT_ACK entry; then IDLE, no core_data_valid_h.
4. rq_par_h wrong -> adr_par_err_h 1 cycle, no mem_start_h, rq_ready_h stays 1.
5. Zero mask, read, adr low=3 -> 4 words delivered as 3,0,1,2.
6. mr_reset_h asserted during RD_DATA after 2 words -> next cycle all outputs 0, no nxm_h; a fresh request is accepted normally afterwards.

Source files
------------

// File: rtl/mbc_pkg.sv
// mbc_pkg: shared state encoding and helpers for the memory-bus request sequencer
package mbc_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT_ACK, RD_DATA, WR_DATA} state_e;
  function automatic logic odd_par(input logic [31:0] v);
    return ~^v;
  endfunction
  // next set bit strictly after idx, wrapping modulo n; returns idx when none
  function automatic logic [3:0] next_word(input logic [15:0] mask, input logic [3:0] idx, input int n);
    logic [3:0] r;
    logic [3:0] j;
    r = idx;
    for (int k = n - 1; k >= 1; k--) begin
      j = 4'((int'(idx) + k) % n);
      if (mask[j]) r = j;
    end
    return r;
  endfunction
endpackage

// File: rtl/mbc_word_rotor.sv
// mbc_word_rotor: finds the first (incl) or next (excl) set mask bit from idx with wrap
module mbc_word_rotor import mbc_pkg::*; #(
  parameter int NWORDS = 4,
  localparam int IW = $clog2(NWORDS)
) (
  input  logic [NWORDS-1:0] mask,
  input  logic [IW-1:0]     idx,
  input  logic              incl,
  output logic [IW-1:0]     nxt,
  output logic              any
);
  always_comb begin
    nxt = (incl && mask[idx]) ? idx : IW'(next_word(16'(mask), 4'(idx), NWORDS));
    any = |mask;
  end
endmodule

// File: rtl/mbc_req_seq.sv
// mbc_req_seq: sequences one masked block read/write on the memory bus with NXM timeout
module mbc_req_seq import mbc_pkg::*; #(
  parameter int NWORDS  = 4,
  parameter int ADR_W   = 14,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 8,
  localparam int IW = $clog2(NWORDS)
) (
  input  logic              clk_mbc_h,
  input  logic              mr_reset_h,
  input  logic              rq_valid_h,
  output logic              rq_ready_h,
  input  logic              rq_wr_h,
  input  logic [NWORDS-1:0] rq_words_h,
  input  logic [ADR_W-1:0]  rq_adr_h,
  input  logic              rq_par_h,
  output logic              mem_start_h,
  output logic [ADR_W-1:0]  mem_adr_h,
  output logic              mem_adr_par_h,
  output logic [NWORDS-1:0] mem_rq_h,
  output logic              mem_rd_rq_h,
  output logic              mem_wr_rq_h,
  input  logic              mem_ackn_h,
  input  logic              mem_data_valid_h,
  output logic              data_valid_out_h,
  output logic [IW-1:0]     word_sel_h,
  output logic              core_data_valid_h,
  output logic              core_busy_h,
  output logic              nxm_h,
  output logic              adr_par_err_h
);
  state_e state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [NWORDS-1:0] mask_q, mask_d, rem_q, rem_d, eff_mask, rem_clr;
  logic [IW-1:0] ptr_q, ptr_d, sel_q, sel_d, first_w, adv_w;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic wr_q, wr_d, cdv_q, cdv_d, perr_q, perr_d, ready_q, ready_d;
  logic first_any, adv_any, busy, par_ok, timing, event_in, to_hit;
  assign eff_mask = (|rq_words_h) ? rq_words_h : '1;
  assign rem_clr  = rem_q & ~(NWORDS'(1) << ptr_q);
  mbc_word_rotor #(.NWORDS(NWORDS)) u_first (
    .mask(eff_mask), .idx(rq_adr_h[IW-1:0]), .incl(1'b1), .nxt(first_w), .any(first_any)
  );
  mbc_word_rotor #(.NWORDS(NWORDS)) u_adv (
    .mask(rem_clr), .idx(ptr_q), .incl(1'b0), .nxt(adv_w), .any(adv_any)
  );
  always_comb begin
    busy     = state_q != IDLE;
    par_ok   = odd_par(32'(rq_adr_h)) == rq_par_h;
    timing   = state_q == WAIT_ACK || state_q == RD_DATA;
    event_in = (state_q == WAIT_ACK && mem_ackn_h) || (state_q == RD_DATA && mem_data_valid_h);
    // an ackn/data-valid landing in the expiry cycle still counts
    to_hit   = timing && !event_in && cnt_q == TO_W'(TIMEOUT);
    state_d  = state_q;
    adr_d    = adr_q;
    wr_d     = wr_q;
    mask_d   = mask_q;
    rem_d    = rem_q;
    ptr_d    = ptr_q;
    sel_d    = sel_q;
    cnt_d    = timing ? cnt_q + 1'b1 : '0;
    cdv_d    = state_q == RD_DATA && mem_data_valid_h;
    perr_d   = 1'b0;
    case (state_q)
      IDLE: if (ready_q && rq_valid_h) begin
        adr_d   = rq_adr_h;
        wr_d    = rq_wr_h;
        mask_d  = eff_mask;
        rem_d   = eff_mask;
        ptr_d   = first_w;
        perr_d  = !par_ok;
        state_d = (par_ok && first_any) ? START : IDLE;
      end
      START: state_d = WAIT_ACK;
      WAIT_ACK: if (mem_ackn_h) begin
        cnt_d   = '0;
        state_d = wr_q ? WR_DATA : RD_DATA;
      end else if (to_hit) state_d = IDLE;
      RD_DATA: if (mem_data_valid_h) begin
        sel_d   = ptr_q;
        rem_d   = rem_clr;
        ptr_d   = adv_w;
        cnt_d   = '0;
        state_d = adv_any ? RD_DATA : IDLE;
      end else if (to_hit) state_d = IDLE;
      WR_DATA: begin
        rem_d   = rem_clr;
        ptr_d   = adv_w;
        state_d = adv_any ? WR_DATA : IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
  end
  always_ff @(posedge clk_mbc_h) begin
    if (mr_reset_h) begin
      state_q <= IDLE;
      adr_q   <= '0;
      wr_q    <= 1'b0;
      mask_q  <= '0;
      rem_q   <= '0;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      cdv_q   <= 1'b0;
      perr_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      cdv_q   <= cdv_d;
      perr_q  <= perr_d;
      ready_q <= ready_d;
    end
  end
  assign rq_ready_h        = ready_q;
  assign mem_start_h       = state_q == START;
  assign mem_adr_h         = busy ? adr_q : '0;
  assign mem_adr_par_h     = busy && odd_par(32'(adr_q));
  assign mem_rq_h          = busy ? mask_q : '0;
  assign mem_rd_rq_h       = busy && !wr_q;
  assign mem_wr_rq_h       = busy && wr_q;
  assign data_valid_out_h  = state_q == WR_DATA;
  assign word_sel_h        = cdv_q ? sel_q : (busy ? ptr_q : '0);
  assign core_data_valid_h = cdv_q;
  assign core_busy_h       = busy;
  assign nxm_h             = to_hit;
  assign adr_par_err_h     = perr_q;
endmodule

// File: tb/tb_mbc_req_seq.sv
// tb_mbc_req_seq: table-driven transactions with a word-order scoreboard plus reset corner sequence
module tb_mbc_req_seq;
  logic clk = 1'b0;
  logic rst, rq_valid, rq_wr, rq_par, mem_ackn, mem_dv;
  logic [3:0] rq_words;
  logic [13:0] rq_adr;
  logic rq_ready_h, mem_start_h, mem_adr_par_h, mem_rd_rq_h, mem_wr_rq_h;
  logic data_valid_out_h, core_data_valid_h, core_busy_h, nxm_h, adr_par_err_h;
  logic [13:0] mem_adr_h;
  logic [3:0] mem_rq_h;
  logic [1:0] word_sel_h;
  logic [28:0] outs_v;

  always #5 clk = ~clk;

  mbc_req_seq #(.NWORDS(4), .ADR_W(14), .TIMEOUT(64), .TO_W(8)) dut (
    .clk_mbc_h(clk), .mr_reset_h(rst), .rq_valid_h(rq_valid), .rq_ready_h(rq_ready_h),
    .rq_wr_h(rq_wr), .rq_words_h(rq_words), .rq_adr_h(rq_adr), .rq_par_h(rq_par),
    .mem_start_h(mem_start_h), .mem_adr_h(mem_adr_h), .mem_adr_par_h(mem_adr_par_h),
    .mem_rq_h(mem_rq_h), .mem_rd_rq_h(mem_rd_rq_h), .mem_wr_rq_h(mem_wr_rq_h),
    .mem_ackn_h(mem_ackn), .mem_data_valid_h(mem_dv), .data_valid_out_h(data_valid_out_h),
    .word_sel_h(word_sel_h), .core_data_valid_h(core_data_valid_h), .core_busy_h(core_busy_h),
    .nxm_h(nxm_h), .adr_par_err_h(adr_par_err_h)
  );

  assign outs_v = {mem_start_h, mem_adr_h, mem_adr_par_h, mem_rq_h, mem_rd_rq_h, mem_wr_rq_h,
                   data_valid_out_h, word_sel_h, core_data_valid_h, core_busy_h, nxm_h, adr_par_err_h};

  typedef struct {
    logic wr; logic [3:0] words; logic [13:0] adr; logic par_ok;
    int ack_at; int gap; int n; logic [1:0] seq [4]; logic [3:0] exp_mask; int nxm_at;
  } txn_t;
  typedef struct { logic [1:0] w; logic wr; } exp_t;

  txn_t tbl[$];
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, base = 0;
  int nstrobe = 0, first_s = 0, last_s = 0, nxm_cnt = 0, nxm_rel = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor samples after the negedge drive so combinational nxm_h has settled.
  always @(negedge clk) begin : mon
    exp_t e;
    #2;
    if (nxm_h) begin
      nxm_cnt++;
      nxm_rel = cyc - base;
    end
    if (core_data_valid_h || data_valid_out_h) begin
      if (nstrobe == 0) first_s = cyc - base;
      last_s = cyc - base;
      nstrobe++;
      chk("strobe_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("word_sel", word_sel_h, e.w);
        chk("write_strobe", data_valid_out_h, e.wr);
        chk("read_strobe", core_data_valid_h, !e.wr);
        if (e.wr) chk("wr_rq_during_write", {mem_wr_rq_h, mem_rd_rq_h}, 2'b10);
      end
    end
  end

  task automatic add(input logic wr, input logic [3:0] words, input logic [13:0] adr, input logic par_ok,
                     input int ack_at, input int gap, input int n, input int w0, input int w1,
                     input int w2, input int w3, input logic [3:0] exp_mask, input int nxm_at);
    txn_t t;
    t.wr = wr; t.words = words; t.adr = adr; t.par_ok = par_ok;
    t.ack_at = ack_at; t.gap = gap; t.n = n;
    t.seq[0] = 2'(w0); t.seq[1] = 2'(w1); t.seq[2] = 2'(w2); t.seq[3] = 2'(w3);
    t.exp_mask = exp_mask; t.nxm_at = nxm_at;
    tbl.push_back(t);
  endtask

  task automatic request(input logic wr, input logic [3:0] words, input logic [13:0] adr, input logic par_ok);
    int guard;
    guard = 0;
    while (rq_ready_h !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_req", rq_ready_h, 1);
    base = cyc; nstrobe = 0; nxm_cnt = 0; nxm_rel = 0;
    rq_valid = 1'b1; rq_wr = wr; rq_words = words; rq_adr = adr;
    rq_par = par_ok ? ~^adr : ^adr;
  endtask

  task automatic run_txn(input txn_t t);
    int guard, k, dvs;
    exp_t e;
    request(t.wr, t.words, t.adr, t.par_ok);
    if (t.par_ok) for (int i = 0; i < t.n; i++) begin
      e.w = t.seq[i]; e.wr = t.wr;
      sb.push_back(e);
    end
    @(negedge clk);
    rq_valid = 1'b0;
    if (!t.par_ok) begin
      chk("par_err_pulse", adr_par_err_h, 1);
      chk("par_err_no_start", mem_start_h, 0);
      chk("par_err_ready", rq_ready_h, 1);
      @(negedge clk);
      chk("par_err_one_cycle", {adr_par_err_h, core_busy_h, mem_start_h}, 0);
      chk("par_err_ready_held", rq_ready_h, 1);
      return;
    end
    chk("start_strobe", mem_start_h, 1);
    chk("mem_adr", mem_adr_h, t.adr);
    chk("mem_adr_par", mem_adr_par_h, ~^t.adr);
    chk("mem_rq", mem_rq_h, t.exp_mask);
    chk("rd_wr_rq", {mem_rd_rq_h, mem_wr_rq_h}, {~t.wr, t.wr});
    dvs = 0; guard = 0;
    while (guard < 400) begin
      @(negedge clk);
      guard++;
      k = cyc - base;
      if (!core_busy_h) break;
      mem_ackn = k == t.ack_at;
      mem_dv = !t.wr && k == 2 && t.ack_at > 2;
      if (!t.wr && t.ack_at > 0 && k > t.ack_at && dvs < t.n && (k - t.ack_at) % t.gap == 0) begin
        mem_dv = 1'b1;
        dvs++;
      end
    end
    mem_ackn = 1'b0; mem_dv = 1'b0;
    #3;
    chk("txn_completes", core_busy_h, 0);
    chk("ready_at_idle", rq_ready_h, 1);
    chk("words_delivered", nstrobe, t.n);
    chk("scoreboard_drained", sb.size(), 0);
    chk("nxm_count", nxm_cnt, 32'(t.nxm_at != 0));
    if (t.nxm_at != 0) chk("nxm_cycle", nxm_rel, t.nxm_at);
    if (t.n > 0) chk("first_strobe_cycle", first_s, t.wr ? t.ack_at + 1 : t.ack_at + t.gap + 1);
    if (t.n > 1) chk("strobe_span", last_s - first_s, t.wr ? t.n - 1 : t.gap * (t.n - 1));
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    exp_t e;
    rst = 1'b1; rq_valid = 1'b0; rq_wr = 1'b0; rq_words = '0; rq_adr = '0; rq_par = 1'b0;
    mem_ackn = 1'b0; mem_dv = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    chk("reset_outputs", outs_v, 0);
    chk("reset_ready", rq_ready_h, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", rq_ready_h, 1);

    //   wr    words    adr       par  ack gap n  sequence     mask     nxm_at
    add(1'b0, 4'b1111, 14'h0006, 1'b1, 3,  2, 4, 2, 3, 0, 1, 4'b1111, 0);
    add(1'b1, 4'b0101, 14'h0011, 1'b1, 4,  1, 2, 2, 0, 0, 0, 4'b0101, 0);
    add(1'b0, 4'b1111, 14'h0100, 1'b1, 0,  1, 0, 0, 0, 0, 0, 4'b1111, 66);
    add(1'b0, 4'b1111, 14'h02A5, 1'b0, 0,  1, 0, 0, 0, 0, 0, 4'b1111, 0);
    add(1'b0, 4'b0000, 14'h3FFF, 1'b1, 2,  1, 4, 3, 0, 1, 2, 4'b1111, 0);
    add(1'b0, 4'b1111, 14'h0001, 1'b1, 3,  3, 2, 1, 2, 0, 0, 4'b1111, 74);
    add(1'b0, 4'b0001, 14'h0000, 1'b1, 66, 2, 1, 0, 0, 0, 0, 4'b0001, 0);
    add(1'b1, 4'b1000, 14'h0003, 1'b1, 2,  1, 1, 3, 0, 0, 0, 4'b1000, 0);
    add(1'b1, 4'b0000, 14'h1232, 1'b1, 5,  1, 4, 2, 3, 0, 1, 4'b1111, 0);
    add(1'b0, 4'b0110, 14'h0A53, 1'b1, 3,  2, 2, 1, 2, 0, 0, 4'b0110, 0);
    add(1'b1, 4'b1010, 14'h0F00, 1'b1, 2,  1, 2, 1, 3, 0, 0, 4'b1010, 0);
    foreach (tbl[i]) run_txn(tbl[i]);

    // reset while RD_DATA has delivered two of four words
    request(1'b0, 4'b1111, 14'h0000, 1'b1);
    e.wr = 1'b0;
    e.w = 2'd0; sb.push_back(e);
    e.w = 2'd1; sb.push_back(e);
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      k = cyc - base;
      rq_valid = 1'b0;
      mem_ackn = k == 3;
      mem_dv = k == 5 || k == 7;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("reset_mid_outputs", outs_v, 0);
    chk("reset_mid_ready", rq_ready_h, 0);
    chk("reset_mid_words", nstrobe, 2);
    repeat (80) @(negedge clk);
    chk("reset_mid_no_nxm", nxm_cnt, 0);
    chk("reset_mid_idle", {core_busy_h, rq_ready_h}, 2'b01);
    sb.delete();
    run_txn(tbl[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
